decode_execute_pipe: RTL and testbench

DECODE_EXECUTE_PIPE -- requirements
Module: decode_execute_pipe

---
 rtl/dex_pkg.sv | 44 ++++
 rtl/dex_entry.sv | 39 +++
 rtl/decode_execute_pipe.sv | 124 ++++++++++++
 tb/tb_decode_execute_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dex_pkg.sv
// ============================================================================
// Module : dex_pkg
// Brief  : Shared types and constants for the decode/execute pipeline register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dex_pkg;

    localparam int DEX_XLEN = 64;
    localparam int DEX_REGW = 5;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       alusrc;
        logic [1:0] aluop;
    } dex_ctrl_t;

    typedef struct packed {
        logic [DEX_XLEN-1:0] pc;
        logic [DEX_XLEN-1:0] imm;
        logic [DEX_XLEN-1:0] rdata1;
        logic [DEX_XLEN-1:0] rdata2;
        logic [DEX_REGW-1:0] rs1;
        logic [DEX_REGW-1:0] rs2;
        logic [DEX_REGW-1:0] rd;
        logic [3:0]          funct4;
        dex_ctrl_t           ctrl;
    } dex_payload_t;

    localparam int DEX_PAYLOAD_W = $bits(dex_payload_t);

endpackage

`default_nettype wire

// File: rtl/dex_entry.sv
// ============================================================================
// Module : dex_entry
// Brief  : One pipeline slot: a valid bit plus a flat payload, with load/clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dex_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clear wins over load so a flush can never be overridden by new data.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/decode_execute_pipe.sv
// ============================================================================
// Module : decode_execute_pipe
// Brief  : Decode->execute valid/ready pipeline register; DEX_SKID_EN adds a
//          skid entry so in_ready comes straight from a flop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_execute_pipe
    import dex_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rdata1,
    input  logic [XLEN-1:0] in_rdata2,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [REGW-1:0] in_rd,
    input  logic [3:0]      in_funct4,
    input  dex_ctrl_t       in_ctrl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic [REGW-1:0] out_rs1,
    output logic [REGW-1:0] out_rs2,
    output logic [REGW-1:0] out_rd,
    output logic [3:0]      out_funct4,
    output dex_ctrl_t       out_ctrl,
    output logic [31:0]     stall_cnt
);

    localparam int PW = 4*XLEN + 3*REGW + 4 + $bits(dex_ctrl_t);

    logic [PW-1:0] w_in_vec;
    logic [PW-1:0] w_m_d;
    logic [PW-1:0] w_m_q;
    logic          w_m_valid;
    logic          w_m_load;
    logic          w_m_clear;
    logic          w_accept;
    logic          w_handoff;
    dex_ctrl_t     w_q_ctrl;
    logic [31:0]   r_stall_cnt;

    assign w_in_vec = {in_pc, in_imm, in_rdata1, in_rdata2,
                       in_rs1, in_rs2, in_rd, in_funct4, in_ctrl};

    assign w_handoff = w_m_valid && out_ready;
    assign w_accept  = in_valid && in_ready;

`ifdef DEX_SKID_EN
    logic [PW-1:0] w_s_q;
    logic          w_s_valid;
    logic          w_s_load;
    logic          w_s_clear;

    assign in_ready = !w_s_valid;

    // The skid refills the main slot first; new data only lands in main when
    // the skid is empty and main is free or draining this cycle.
    assign w_m_d     = w_s_valid ? w_s_q : w_in_vec;
    assign w_m_load  = !flush && ((w_s_valid && w_handoff) ||
                                  (!w_s_valid && w_accept && (!w_m_valid || w_handoff)));
    assign w_m_clear = flush || (w_handoff && !w_m_load);
    assign w_s_load  = !flush && !w_s_valid && w_accept && w_m_valid && !out_ready;
    assign w_s_clear = flush || (w_s_valid && w_handoff);

    dex_entry #(.W(PW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_data  (w_in_vec),
        .o_valid (w_s_valid),
        .o_data  (w_s_q)
    );
`else
    assign in_ready  = !w_m_valid || out_ready;
    assign w_m_d     = w_in_vec;
    assign w_m_load  = !flush && w_accept;
    assign w_m_clear = flush || (w_handoff && !w_accept);
`endif

    dex_entry #(.W(PW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_d),
        .o_valid (w_m_valid),
        .o_data  (w_m_q)
    );

    assign {out_pc, out_imm, out_rdata1, out_rdata2,
            out_rs1, out_rs2, out_rd, out_funct4, w_q_ctrl} = w_m_q;

    // A bubble must never carry write enables downstream.
    assign out_ctrl  = w_m_valid ? w_q_ctrl : '0;
    assign out_valid = w_m_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !out_ready && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_execute_pipe.sv
// ============================================================================
// Module : tb_decode_execute_pipe
// Brief  : Self-checking bench: FIFO reference model plus directed literals.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_execute_pipe;
    import dex_pkg::*;

`ifdef DEX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  f4;
        logic [7:0]  ctrl;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [63:0] in_pc, in_imm, in_rdata1, in_rdata2;
    logic [63:0] out_pc, out_imm, out_rdata1, out_rdata2;
    logic [4:0]  in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
    logic [3:0]  in_funct4, out_funct4;
    dex_ctrl_t   in_ctrl, out_ctrl;
    logic [31:0] stall_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    beat_t       mq[$];
    logic [31:0] m_cnt = 0;
    int          n_acc = 0;

    always #5 clk = ~clk;

    decode_execute_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_funct4(in_funct4),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct4(out_funct4),
        .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.pc   = {$urandom, $urandom};
        b.imm  = {$urandom, $urandom};
        b.r1   = {$urandom, $urandom};
        b.r2   = {$urandom, $urandom};
        b.rs1  = 5'($urandom);
        b.rs2  = 5'($urandom);
        b.rd   = 5'($urandom);
        b.f4   = 4'($urandom);
        b.ctrl = 8'($urandom);
        return b;
    endfunction

    function automatic beat_t mk_beat(input logic [63:0] pc);
        beat_t b;
        b      = rand_beat();
        b.pc   = pc;
        b.ctrl = b.ctrl | 8'h08;
        return b;
    endfunction

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic step(input logic rst, input logic iv, input logic ordy,
                        input logic fl, input beat_t b);
        logic  exp_valid, exp_ready, acc, hand;
        beat_t dut_b;
        @(negedge clk);
        reset = rst; in_valid = iv; out_ready = ordy; flush = fl;
        in_pc = b.pc; in_imm = b.imm; in_rdata1 = b.r1; in_rdata2 = b.r2;
        in_rs1 = b.rs1; in_rs2 = b.rs2; in_rd = b.rd; in_funct4 = b.f4;
        in_ctrl = dex_ctrl_t'(b.ctrl);
        #1;
        exp_valid = (mq.size() > 0);
        exp_ready = (CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || ordy);
        chk("out_valid", 320'(out_valid), 320'(exp_valid));
        chk("in_ready", 320'(in_ready), 320'(exp_ready));
        chk("stall_cnt", 320'(stall_cnt), 320'(m_cnt));
        if (exp_valid) begin
            dut_b = {out_pc, out_imm, out_rdata1, out_rdata2, out_rs1, out_rs2,
                     out_rd, out_funct4, 8'(out_ctrl)};
            chk("payload", 320'(dut_b), 320'(mq[0]));
        end else begin
            chk("bubble_ctrl", 320'(out_ctrl), 320'(0));
        end
        acc  = iv && exp_ready;
        hand = exp_valid && ordy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cnt = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (exp_valid && !ordy && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (hand) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(b);
                n_acc++;
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, ordy, 1'b0, rand_beat());
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, mk_beat(64'hDEAD));
        step(1'b1, 1'b1, 1'b0, 1'b0, mk_beat(64'hDEAD));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pc = '0; in_imm = '0; in_rdata1 = '0; in_rdata2 = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_funct4 = '0; in_ctrl = '0;

        // Reset with in_valid held high
        do_reset();
        chk("rst_out_valid", 320'(out_valid), 320'(0));
        chk("rst_out_ctrl", 320'(out_ctrl), 320'(0));
        chk("rst_stall_cnt", 320'(stall_cnt), 320'(0));
        chk("rst_in_ready", 320'(in_ready), 320'(1));
        idle(1'b0);
        chk("post_rst_in_ready", 320'(in_ready), 320'(1));

        // Four-beat stream, 1-cycle latency
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, mk_beat(64'h100 + 64'(4*i)));
            chk("stream_valid", 320'(out_valid), 320'(1));
            chk("stream_pc", 320'(out_pc), 320'(64'h100 + 64'(4*i)));
        end
        idle(1'b1);
        chk("stream_done", 320'(out_valid), 320'(0));

        // Five-cycle stall holding pc 0x200
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, mk_beat(64'h200));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, mk_beat(64'h204));
        chk("stall_pc", 320'(out_pc), 320'(64'h200));
        chk("stall_cnt5", 320'(stall_cnt), 320'(5));
`ifdef DEX_SKID_EN
        chk("skid_in_ready", 320'(in_ready), 320'(0));
`endif
        idle(1'b1);
`ifdef DEX_SKID_EN
        chk("skid_drain_pc", 320'(out_pc), 320'(64'h204));
`endif
        idle(1'b1);
        idle(1'b1);

        // Flush with held entries and a beat presented in the flush cycle
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, mk_beat(64'h2F0));
        step(1'b0, 1'b1, 1'b0, 1'b0, mk_beat(64'h2F4));
        step(1'b0, 1'b1, 1'b1, 1'b1, mk_beat(64'h300));
        chk("flush_valid", 320'(out_valid), 320'(0));
        chk("flush_ctrl", 320'(out_ctrl), 320'(0));
        idle(1'b1);
        chk("flush_no_300", 320'(out_valid), 320'(0));

        // Saturation from a forced near-max count
        do_reset();
        #1 force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1 release dut.r_stall_cnt;
        m_cnt = 32'hFFFF_FFFE;
        step(1'b0, 1'b1, 1'b0, 1'b0, mk_beat(64'h400));
        for (int i = 0; i < 3; i++) idle(1'b0);
        chk("stall_sat", 320'(stall_cnt), 320'(32'hFFFF_FFFF));
        idle(1'b1);

        // Random traffic, occasional flush and reset
        do_reset();
        n_acc = 0;
        for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 299) == 0), rand_beat());
        end
        chk("random_beats_accepted", 320'(n_acc >= 10000), 320'(1));
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("drain_empty", 320'(out_valid), 320'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
